// File: rtl/ps2_ascii_pkg.sv
// rtl/ps2_ascii_pkg.sv - scancode constants and PS/2 set-2 to ASCII table
//
// Shared by the decoder and, later, by the filename-paste encoder so both
// directions use one table.
//   sc_to_ascii(code, shift) returns {hit, ascii[7:0]}; hit=0 means drop.

package ps2_ascii_pkg;

  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_MINUS  = 8'h4E;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_PERIOD = 8'h49;
  localparam logic [7:0] SC_AT     = 8'h54;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_BS   = 8'h08;
  localparam logic [7:0] ASCII_SP   = 8'h20;
  localparam logic [7:0] ASCII_DASH = 8'h2D;
  localparam logic [7:0] ASCII_STAR = 8'h2A;

  // Letters ignore shift: the EG2000 keyboard only produces uppercase.
  function automatic logic [8:0] sc_to_ascii(input logic [7:0] code, input logic shift);
    logic [8:0] r;
    r = 9'h000;
    case (code)
      SC_SPACE:  r = {1'b1, ASCII_SP};
      SC_PERIOD: r = {1'b1, 8'h2E};
      SC_AT:     r = {1'b1, 8'h40};
      SC_ENTER:  r = {1'b1, ASCII_CR};
      SC_BKSP:   r = {1'b1, ASCII_BS};
      SC_MINUS:  r = {1'b1, shift ? ASCII_STAR : ASCII_DASH};
      // digits
      8'h45: r = {1'b1, 8'h30};
      8'h16: r = {1'b1, 8'h31};
      8'h1E: r = {1'b1, 8'h32};
      8'h26: r = {1'b1, 8'h33};
      8'h25: r = {1'b1, 8'h34};
      8'h2E: r = {1'b1, 8'h35};
      8'h36: r = {1'b1, 8'h36};
      8'h3D: r = {1'b1, 8'h37};
      8'h3E: r = {1'b1, 8'h38};
      8'h46: r = {1'b1, 8'h39};
      // letters
      8'h1C: r = {1'b1, 8'h41};
      8'h32: r = {1'b1, 8'h42};
      8'h21: r = {1'b1, 8'h43};
      8'h23: r = {1'b1, 8'h44};
      8'h24: r = {1'b1, 8'h45};
      8'h2B: r = {1'b1, 8'h46};
      8'h34: r = {1'b1, 8'h47};
      8'h33: r = {1'b1, 8'h48};
      8'h43: r = {1'b1, 8'h49};
      8'h3B: r = {1'b1, 8'h4A};
      8'h42: r = {1'b1, 8'h4B};
      8'h4B: r = {1'b1, 8'h4C};
      8'h3A: r = {1'b1, 8'h4D};
      8'h31: r = {1'b1, 8'h4E};
      8'h44: r = {1'b1, 8'h4F};
      8'h4D: r = {1'b1, 8'h50};
      8'h15: r = {1'b1, 8'h51};
      8'h2D: r = {1'b1, 8'h52};
      8'h1B: r = {1'b1, 8'h53};
      8'h2C: r = {1'b1, 8'h54};
      8'h3C: r = {1'b1, 8'h55};
      8'h2A: r = {1'b1, 8'h56};
      8'h1D: r = {1'b1, 8'h57};
      8'h22: r = {1'b1, 8'h58};
      8'h35: r = {1'b1, 8'h59};
      8'h1A: r = {1'b1, 8'h5A};
      default: r = 9'h000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ascii_fifo.sv
// rtl/ascii_fifo.sv - show-ahead synchronous character FIFO
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   wr_en, wr_data    push request and character
//   rd_en             pop request (ignored when empty)
//   rd_data           head entry, 8'h00 when empty
//   count/full/empty  occupancy
// A push while full succeeds only when a pop happens on the same edge.

module ascii_fifo #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          full,
  output logic                          empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("ascii_fifo: FIFO_DEPTH must be a power of two >= 2");
  end

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign full  = (count == (AW+1)'(FIFO_DEPTH));
  assign empty = (count == '0);

  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  // No bypass: an empty FIFO shows zero even while a write is in flight.
  assign rd_data = empty ? 8'h00 : mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/ps2_key_ascii_decoder.sv
// rtl/ps2_key_ascii_decoder.sv - MiSTer ps2_key event stream to buffered ASCII
//
// Ports:
//   clk, reset   clk_sys, synchronous active-high reset
//   ps2_key      [10] toggle, [9] pressed, [8] extended, [7:0] scancode
//   ascii/valid  FIFO head and not-empty; consumed when valid & ready
//   ready        consumer accept
//   shift_held   either shift key currently held
//   overflow     sticky: a character was lost to a full FIFO
//   fifo_count   current FIFO occupancy

module ps2_key_ascii_decoder
  import ps2_ascii_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [10:0]                  ps2_key,
  output logic [7:0]                   ascii,
  output logic                         valid,
  input  logic                         ready,
  output logic                         shift_held,
  output logic                         overflow,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  logic       old_toggle;
  logic       lshift;
  logic       rshift;
  logic       push_q;
  logic [7:0] char_q;
  logic       key_event;
  logic       key_pressed;
  logic       key_ext;
  logic [7:0] key_code;
  logic [8:0] lookup;
  logic       pop;
  logic       fifo_full;
  logic       fifo_empty;

  assign key_event   = ps2_key[10] ^ old_toggle;
  assign key_pressed = ps2_key[9];
  assign key_ext     = ps2_key[8];
  assign key_code    = ps2_key[7:0];

  // Shift is the registered state, so a key arriving the cycle after a
  // shift press already sees it.
  assign shift_held = lshift | rshift;
  assign lookup     = sc_to_ascii(key_code, shift_held);

  assign valid = !fifo_empty;
  assign pop   = valid && ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      // Track the live toggle so a toggle pending across reset is swallowed.
      old_toggle <= ps2_key[10];
      lshift     <= 1'b0;
      rshift     <= 1'b0;
      push_q     <= 1'b0;
      char_q     <= 8'h00;
      overflow   <= 1'b0;
    end else begin
      old_toggle <= ps2_key[10];
      push_q     <= 1'b0;
      if (key_event && !key_ext) begin
        if (key_code == SC_LSHIFT) begin
          lshift <= key_pressed;
        end else if (key_code == SC_RSHIFT) begin
          rshift <= key_pressed;
        end else if (key_pressed) begin
          push_q <= lookup[8];
          char_q <= lookup[7:0];
        end
      end
      if (push_q && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  ascii_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push_q),
    .wr_data (char_q),
    .rd_en   (pop),
    .rd_data (ascii),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_ps2_key_ascii_decoder.sv
// tb/tb_ps2_key_ascii_decoder.sv - scoreboard bench for ps2_key_ascii_decoder

module tb_ps2_key_ascii_decoder;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          reset;
  logic [10:0]   ps2_key;
  logic [7:0]    ascii;
  logic          valid;
  logic          ready;
  logic          shift_held;
  logic          overflow;
  logic [CW-1:0] fifo_count;

  ps2_key_ascii_decoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_key    (ps2_key),
    .ascii      (ascii),
    .valid      (valid),
    .ready      (ready),
    .shift_held (shift_held),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Character table written as plain strings paired with scancodes.
  bit [7:0] cmap [int];
  initial begin
    string    letters;
    string    digits;
    bit [7:0] lc [26];
    bit [7:0] dc [10];
    letters = "ABCDEFGHIJKLMNOPQRSTUVWXYZ";
    digits  = "0123456789";
    lc = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
           8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
           8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    dc = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    for (int i = 0; i < 26; i++) cmap[int'(lc[i])] = letters[i];
    for (int i = 0; i < 10; i++) cmap[int'(dc[i])] = digits[i];
    cmap[8'h29] = " ";
    cmap[8'h49] = ".";
    cmap[8'h54] = "@";
    cmap[8'h5A] = 8'h0D;
    cmap[8'h66] = 8'h08;
  end

  // Reference model: held-key set, pending character, queue of stored chars.
  bit [7:0] m_q [$];
  bit       m_held [int];
  bit       m_stage_v;
  bit [7:0] m_stage_c;
  bit       m_ovf;
  bit       m_old;

  always @(posedge clk) begin
    int       code;
    bit [7:0] dummy;
    if (reset) begin
      m_q.delete();
      m_held.delete();
      m_stage_v = 1'b0;
      m_ovf     = 1'b0;
      m_old     = ps2_key[10];
    end else begin
      if (m_q.size() > 0 && ready) dummy = m_q.pop_front();
      if (m_stage_v) begin
        if (m_q.size() < DEPTH) m_q.push_back(m_stage_c);
        else m_ovf = 1'b1;
      end
      m_stage_v = 1'b0;
      if (ps2_key[10] != m_old && !ps2_key[8]) begin
        code = int'(ps2_key[7:0]);
        if (code == 8'h12 || code == 8'h59) begin
          if (ps2_key[9]) m_held[code] = 1'b1;
          else m_held.delete(code);
        end else if (ps2_key[9]) begin
          if (code == 8'h4E) begin
            m_stage_v = 1'b1;
            m_stage_c = (m_held.size() > 0) ? 8'h2A : 8'h2D;
          end else if (cmap.exists(code)) begin
            m_stage_v = 1'b1;
            m_stage_c = cmap[code];
          end
        end
      end
      m_old = ps2_key[10];
    end
  end

  // Monitor: pops are checked against the queue head; occupancy every cycle.
  bit       mon_en = 1'b0;
  bit [7:0] last_pop;
  always @(negedge clk) begin
    if (mon_en) begin
      if (valid && ready) begin
        chk("pop_data", int'(ascii), (m_q.size() > 0) ? int'(m_q[0]) : -1);
        last_pop = ascii;
      end
      chk("head",       int'(ascii), (m_q.size() > 0) ? int'(m_q[0]) : 0);
      chk("valid",      int'(valid), int'(m_q.size() > 0));
      chk("fifo_count", int'(fifo_count), m_q.size());
      chk("overflow",   int'(overflow), int'(m_ovf));
      chk("shift_held", int'(shift_held), int'(m_held.size() > 0));
    end
  end

  int rdy_mode = 0;
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 2) ready = 1'($urandom_range(0, 1));
  end

  task automatic send(input bit pressed, input bit ext, input bit [7:0] code);
    @(posedge clk); #1;
    ps2_key = {~ps2_key[10], pressed, ext, code};
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic send_digits(input int n);
    bit [7:0] dc [10];
    dc = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    for (int i = 1; i <= n; i++) send(1'b1, 1'b0, dc[i % 10]);
  endtask

  initial begin
    bit [7:0] pool [14];
    pool = '{8'h12, 8'h59, 8'h4E, 8'h1C, 8'h45, 8'h16, 8'h29, 8'h49,
             8'h54, 8'h5A, 8'h66, 8'h76, 8'h24, 8'h1A};
    reset   = 1'b1;
    ps2_key = 11'h000;
    ready   = 1'b0;
    do_reset();
    idle(1);
    chk("rst_valid", int'(valid), 0);
    chk("rst_count", int'(fifo_count), 0);

    // single key, two-cycle latency
    send(1'b1, 1'b0, 8'h1C);
    @(negedge clk); chk("lat0_valid", int'(valid), 0);
    @(negedge clk); chk("lat1_valid", int'(valid), 0);
    @(negedge clk); chk("lat2_valid", int'(valid), 1);
    chk("lat2_ascii", int'(ascii), 8'h41);
    send(1'b0, 1'b0, 8'h1C);
    idle(4);
    chk("release_count", int'(fifo_count), 1);
    ready = 1'b1; idle(2); ready = 1'b0;

    // shift handling
    send(1'b1, 1'b0, 8'h12);
    send(1'b1, 1'b0, 8'h4E);
    send(1'b0, 1'b0, 8'h4E);
    send(1'b0, 1'b0, 8'h12);
    send(1'b1, 1'b0, 8'h4E);
    idle(4);
    chk("shift_count", int'(fifo_count), 2);
    chk("shift_head", int'(ascii), 8'h2A);
    ready = 1'b1; idle(4); ready = 1'b0;

    // dropped events
    send(1'b1, 1'b1, 8'h5A);
    send(1'b1, 1'b0, 8'h76);
    idle(4);
    chk("drop_count", int'(fifo_count), 0);

    // randomized traffic with random back-pressure
    rdy_mode = 2;
    for (int i = 0; i < 400; i++) begin
      bit [7:0] code;
      code = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, 13)];
      send(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0), code);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rdy_mode = 0;
    ready = 1'b1; idle(20); ready = 1'b0;

    // overflow
    do_reset();
    send_digits(9);
    idle(4);
    chk("ovf_count", int'(fifo_count), 8);
    chk("ovf_flag", int'(overflow), 1);
    ready = 1'b1; idle(12); ready = 1'b0;
    chk("ovf_last", int'(last_pop), 8'h38);
    chk("ovf_drained", int'(valid), 0);

    // full with simultaneous push and pop
    do_reset();
    send_digits(8);
    idle(3);
    send(1'b1, 1'b0, 8'h24);
    @(posedge clk); #1; ready = 1'b1;
    @(posedge clk); #1; ready = 1'b0;
    @(negedge clk);
    chk("pp_count", int'(fifo_count), 8);
    chk("pp_ovf", int'(overflow), 0);
    ready = 1'b1; idle(12); ready = 1'b0;
    chk("pp_last", int'(last_pop), 8'h45);

    // reset mid-stream with a pending toggle
    send(1'b1, 1'b0, 8'h12);
    send(1'b1, 1'b0, 8'h1C);
    send(1'b1, 1'b0, 8'h32);
    send(1'b1, 1'b0, 8'h21);
    idle(3);
    chk("mid_count", int'(fifo_count), 3);
    @(posedge clk); #1;
    reset   = 1'b1;
    ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h23};
    @(posedge clk); #1;
    reset = 1'b0;
    idle(4);
    chk("mid_valid", int'(valid), 0);
    chk("mid_ascii", int'(ascii), 0);
    chk("mid_count0", int'(fifo_count), 0);
    chk("mid_shift", int'(shift_held), 0);
    chk("mid_ovf", int'(overflow), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
